// File: rtl/ufm_ctrl.sv
// ufm_ctrl: single-word read/write controller driving the UFM serial address/data shift interface
module ufm_ctrl #(
   parameter int CLKDIV = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [8:0]  address,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        arclk,
   output logic        ardin,
   output logic        arshft,
   output logic        drclk,
   output logic        drdin,
   output logic        drshft,
   input  logic        drdout,
   output logic        prgram
);
   localparam int PW = CLKDIV > 1 ? $clog2(CLKDIV) : 1;
   typedef enum logic [2:0] {IDLE, ASHIFT, AINC, LOAD, RSHIFT, WSHIFT, PROG, DONE} state_t;
   state_t state, nxt;
   logic [PW-1:0] ph;
   logic hi, is_wr, addr_valid, ph_end, pe, sample, accept;
   logic [4:0] cnt;
   logic [8:0] areg, addr_r, last_addr;
   logic [15:0] sh;
   assign ph_end = ph == PW'(CLKDIV - 1);
   assign pe = hi && ph_end;
   assign sample = !hi && ph_end && state == RSHIFT;
   assign accept = state == IDLE && (wr || rd);
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= nxt;
   // Serial lines are decoded from state and phase so reset drops every clock line at once.
   always_comb begin
      nxt = state;
      arclk = 1'b0;
      ardin = 1'b0;
      arshft = 1'b0;
      drclk = 1'b0;
      drdin = 1'b0;
      drshft = 1'b0;
      prgram = 1'b0;
      busy = state != IDLE;
      done = state == DONE;
      case (state)
         IDLE:
            if (wr) nxt = ASHIFT;
            else if (rd) nxt = addr_valid && address == last_addr + 9'd1 ? AINC : ASHIFT;
         ASHIFT: begin
            arclk = hi;
            arshft = 1'b1;
            ardin = areg[8];
            if (pe && cnt == 5'd8) nxt = is_wr ? WSHIFT : LOAD;
         end
         AINC: begin
            arclk = hi;
            if (pe) nxt = LOAD;
         end
         LOAD: begin
            drclk = hi;
            if (pe) nxt = RSHIFT;
         end
         RSHIFT: begin
            drclk = hi;
            drshft = 1'b1;
            if (pe && cnt == 5'd15) nxt = DONE;
         end
         WSHIFT: begin
            drclk = hi;
            drshft = 1'b1;
            drdin = sh[15];
            if (pe && cnt == 5'd15) nxt = PROG;
         end
         PROG: begin
            prgram = hi;
            if (pe) nxt = DONE;
         end
         DONE: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         ph <= '0;
         hi <= 1'b0;
         cnt <= '0;
         areg <= '0;
         addr_r <= '0;
         last_addr <= '0;
         addr_valid <= 1'b0;
         is_wr <= 1'b0;
         sh <= '0;
         rdata <= '0;
      end else begin
         if (accept) begin
            areg <= address;
            addr_r <= address;
            sh <= wdata;
            is_wr <= wr;
         end
         if (state != IDLE && state != DONE) begin
            ph <= ph_end ? '0 : ph + 1'b1;
            if (ph_end) hi <= !hi;
         end
         cnt <= nxt != state ? 5'd0 : pe ? cnt + 5'd1 : cnt;
         if (pe && state == ASHIFT) areg <= areg << 1;
         if (pe && state == WSHIFT) sh <= sh << 1;
         // drdout is captured just before the rising drclk that shifts the next bit up.
         if (sample) sh <= {sh[14:0], drdout};
         if (pe && state == RSHIFT && cnt == 5'd15) rdata <= sh;
         if (state == DONE) begin
            last_addr <= addr_r;
            addr_valid <= 1'b1;
         end
      end
endmodule

// File: tb/tb_ufm_ctrl.sv
// tb_ufm_ctrl: scoreboard bench for ufm_ctrl against a behavioural UFM model
module tb_ufm_ctrl;
   logic clock = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0;
   logic [8:0] address = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic busy, done, arclk, ardin, arshft, drclk, drdin, drshft, drdout, prgram;
   ufm_ctrl #(.CLKDIV(1)) dut (
      .clock(clock), .reset(reset), .rd(rd), .wr(wr), .address(address), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .arclk(arclk), .ardin(ardin), .arshft(arshft),
      .drclk(drclk), .drdin(drdin), .drshft(drshft), .drdout(drdout), .prgram(prgram)
   );
   always #5 clock = ~clock;
   logic [15:0] ufm_mem [512];
   logic [8:0] ua = '0, pl_a = '0, shifted = '0;
   logic [15:0] ud = '0, pl_d = '0;
   logic pl_we = 1'b0;
   assign drdout = ud[15];
   always @(posedge arclk) ua <= arshft ? {ua[7:0], ardin} : ua + 9'd1;
   always @(posedge drclk) ud <= drshft ? {ud[14:0], drdin} : ufm_mem[ua];
   always @(posedge prgram or posedge pl_we)
      if (pl_we) ufm_mem[pl_a] <= pl_d;
      else ufm_mem[ua] <= ud;
   int ash_cnt = 0, inc_cnt = 0, prg_cnt = 0, done_cnt = 0, cyc = 0;
   always @(posedge arclk)
      if (arshft) begin
         ash_cnt <= ash_cnt + 1;
         shifted <= {shifted[7:0], ardin};
      end else inc_cnt <= inc_cnt + 1;
   always @(posedge prgram) prg_cnt <= prg_cnt + 1;
   always @(negedge clock) if (done) done_cnt <= done_cnt + 1;
   always @(posedge clock) cyc <= cyc + 1;
   typedef struct {int cyc; logic [15:0] data;} exp_t;
   exp_t sbq[$];
   logic [15:0] exp_mem [512];
   logic [15:0] rdata_exp = '0;
   logic [8:0] last = '0;
   bit valid = 1'b0;
   int n_cmp = 0, n_bad = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic preload(input logic [8:0] a, input logic [15:0] d);
      pl_a = a;
      pl_d = d;
      exp_mem[a] = d;
      #1 pl_we = 1'b1;
      #1 pl_we = 1'b0;
   endtask
   task automatic op(input bit w, input bit r, input logic [8:0] a, input logic [15:0] d, input bit poke);
      exp_t e;
      int a0, i0, p0, d0;
      bit inc, got;
      @(negedge clock);
      inc = !w && valid && a == 9'(last + 9'd1);
      if (!w) rdata_exp = exp_mem[a];
      else exp_mem[a] = d;
      e.cyc = cyc + (inc ? 37 : 53);
      e.data = rdata_exp;
      sbq.push_back(e);
      a0 = ash_cnt; i0 = inc_cnt; p0 = prg_cnt; d0 = done_cnt;
      wr = w; rd = r; address = a; wdata = d;
      @(negedge clock);
      wr = 1'b0; rd = 1'b0; address = 9'($urandom); wdata = 16'($urandom);
      check("busy_rise", busy, 1);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         rd = poke && i == 8;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      rd = 1'b0;
      if (got) begin
         e = sbq.pop_front();
         check("done_cycle", cyc, e.cyc);
         check("rdata", rdata, e.data);
      end else begin
         check("done_timeout", 0, 1);
         sbq.delete();
      end
      @(negedge clock);
      check("done_one_cycle", done, 0);
      check("busy_fall", busy, 0);
      check("rdata_hold", rdata, rdata_exp);
      check("arclk_shift", ash_cnt - a0, inc ? 0 : 9);
      check("arclk_inc", inc_cnt - i0, inc ? 1 : 0);
      check("prgram_pulses", prg_cnt - p0, w ? 1 : 0);
      if (!inc) check("addr_bits", shifted, a);
      repeat (4) @(negedge clock);
      check("done_pulses", done_cnt - d0, 1);
      if (w) check("ufm_word", ufm_mem[a], d);
      last = a;
      valid = 1'b1;
   endtask
   initial begin
      int p0;
      preload(9'h005, 16'hBEEF);
      preload(9'h006, 16'h1357);
      preload(9'h1FF, 16'hAAAA);
      preload(9'h000, 16'h5555);
      preload(9'h01F, 16'h7E57);
      preload(9'h020, 16'h0F0F);
      repeat (3) @(negedge clock);
      check("reset_state", {rdata, busy, done, arclk, ardin, arshft, drclk, drdin, drshft, prgram}, 0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_state", {rdata, busy, done, arclk, arshft, drclk, drshft, prgram}, 0);
      op(0, 1, 9'h005, 16'h0000, 0);
      op(0, 1, 9'h006, 16'h0000, 0);
      op(1, 0, 9'h1A5, 16'h1234, 0);
      op(0, 1, 9'h1A5, 16'h0000, 0);
      op(0, 1, 9'h1FF, 16'h0000, 0);
      op(0, 1, 9'h000, 16'h0000, 0);
      op(1, 1, 9'h010, 16'hCAFE, 1);
      op(0, 1, 9'h01F, 16'h0000, 0);
      // Interrupted write to the address that would otherwise qualify for an increment.
      @(negedge clock);
      p0 = prg_cnt;
      wr = 1'b1; address = 9'h020; wdata = 16'hDEAD;
      @(negedge clock);
      wr = 1'b0;
      repeat (19) @(negedge clock);
      reset = 1'b1;
      #1 check("reset_mid_op", {rdata, busy, done, arclk, ardin, arshft, drclk, drdin, drshft, prgram}, 0);
      @(negedge clock);
      reset = 1'b0;
      check("no_prgram", prg_cnt - p0, 0);
      check("ufm_unchanged", ufm_mem[9'h020], 16'h0F0F);
      valid = 1'b0;
      rdata_exp = '0;
      op(0, 1, 9'h020, 16'h0000, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ufm_ctrl.md
# ufm_ctrl

Parallel-to-serial controller for the UFM block. It takes single-word read/write requests from the AVR core side (9-bit word address, 16-bit data) and drives the UFM serial address/data shift interface. It sits directly upstream of `ufm_emu` (or the real UFM primitive), with its outputs wired one-to-one to the UFM pins. Consecutive-address reads reuse the UFM address counter instead of reshifting the address.

## Interface
- `CLKDIV`, default 1: system cycles per serial-clock phase. One serial bit period = 2*CLKDIV cycles.
- `clock`  in  1  system clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high reset
- `rd`  in  1  read request; sampled in IDLE only
- `wr`  in  1  write request; sampled in IDLE only; wins over `rd`
- `address`  in  9  word address; captured on accept
- `wdata`  in  16  write data; captured on accept
- `rdata`  out  16  last word read; held until the next read completes
- `busy`  out  1  high from the cycle after accept until `done`, inclusive
- `done`  out  1  one-cycle completion pulse
- `arclk`, `ardin`, `arshft`  out  1 each  UFM address register clock/data/shift
- `drclk`, `drdin`, `drshft`  out  1 each  UFM data register clock/data/shift
- `drdout`  in  1  UFM data register MSB
- `prgram`  out  1  UFM program strobe

## Operation
- UFM semantics relied on:
  - `arclk` rise with `arshft`=1 shifts `ardin` into the address LSB. With `arshft`=0 it increments the address, wrapping mod 512.
  - `drclk` rise with `drshft`=0 loads the word. With `drshft`=1 it shifts left, taking `drdin` into the LSB.
  - `drdout` is the data MSB.
  - `prgram` rise writes the data register to the current address.
- Serial pulse: a low phase of CLKDIV cycles with data/shift lines set up, then a high phase of CLKDIV cycles with the clock (or `prgram`) high. Lines stay stable across both phases.
- States: IDLE, ASHIFT, AINC, LOAD, RSHIFT, WSHIFT, PROG, DONE.
- IDLE:
  - `wr` → capture `address`/`wdata` → ASHIFT.
  - `rd` with `addr_valid` and `address == last_addr+1` (mod 512) → AINC.
  - Any other `rd` → ASHIFT.
- ASHIFT: 9 `arclk` pulses, `arshft`=1, address MSB first (bit 8..0). Then → WSHIFT for a write, LOAD for a read.
- AINC: 1 `arclk` pulse, `arshft`=0 → LOAD.
- LOAD: 1 `drclk` pulse, `drshft`=0 → RSHIFT.
- RSHIFT:
  - 16 iterations of: sample `drdout` into the shift register at the last cycle of the low phase, then 1 `drclk` pulse with `drshft`=1 and `drdin`=0.
  - The first sample is bit 15.
  - Then `rdata` is updated → DONE.
- WSHIFT: 16 `drclk` pulses, `drshft`=1, `wdata` MSB first → PROG.
- PROG: 1 `prgram` pulse, `drshft`=0 → DONE.
- DONE: `done`=1 for one cycle; `last_addr` ← captured address, `addr_valid` ← 1 → IDLE.
- Bit counter is 5 bits. The phase counter counts 0..CLKDIV-1.
- Wrap-around: `last_addr`=511 with request 0 qualifies for AINC.
- Requests while not IDLE are ignored, not queued.

## Timing
- Reset values:
  - All serial outputs and `prgram` = 0.
  - `busy`=0, `done`=0, `rdata`=0x0000.
  - `addr_valid`=0, state IDLE.
- Accept at cycle N (IDLE, request high). `busy`=1 from N+1.
- Bit periods P:
  - Full read: 9+1+16 = 26.
  - Incremental read: 1+1+16 = 18.
  - Write: 9+16+1 = 26.
- `done` is high at cycle N+1+2*CLKDIV*P. With CLKDIV=1: full read/write at N+53, incremental read at N+37.
- `rdata` is valid in the `done` cycle and held afterward.
- `busy` falls the cycle after `done`. A new request is accepted that cycle at the earliest.
- Reset mid-operation:
  - Forces reset values immediately, including clocks low.
  - Clears `addr_valid`, so the next read always does a full address shift.
  - A write interrupted before the `prgram` rise leaves UFM contents unchanged.

## Test plan
- Preload ufm[0x005]=0xBEEF, rd `address`=0x005 after reset → 9 `arclk` pulses with `arshft`=1 shifting 0b000000101, `done` at accept+53, `rdata`=0xBEEF.
- Preload ufm[0x006]=0x1357, rd 0x005 then rd 0x006 → second op has exactly one `arclk` pulse with `arshft`=0, `done` at accept+37, `rdata`=0x1357.
- wr 0x1A5/0x1234 → exactly one `prgram` pulse, `done` at accept+53; then rd 0x1A5 → `rdata`=0x1234 via full address shift.
- Preload ufm[0x1FF]=0xAAAA and ufm[0x000]=0x5555, rd 0x1FF then rd 0x000 → second op uses AINC, `rdata`=0x5555.
- `rd` and `wr` high together with `address`=0x010, `wdata`=0xCAFE → write performed and ufm[0x010]=0xCAFE. Pulsing `rd` mid-operation → no extra `done`.
- Assert `reset` at cycle 20 of a write to 0x020 (old value 0x0F0F) → all outputs 0 next edge, no `prgram`. A following rd 0x020 uses full shift and returns 0x0F0F.
